program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 64, address width of the instruction-memory debug port.
- INSTRUCTION_LENGTH, 32, instruction width.
- BASE_ADDR, 0, byte address of the first loaded instruction.
- MAX_WORDS, 1024, largest accepted word count.
- TIMEOUT_CYCLES, 1000000, allowed idle gap between bytes once a load has started.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  serial-link byte.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1 at a clk edge.
- reload  in  1  pulse that restarts loading from DONE or ERROR.
- dbg_wr_en  out  1  instruction-memory write strobe, drives the core debug port.
- dbg_addr  out  XLEN  instruction-memory byte address.
- dbg_instr  out  INSTRUCTION_LENGTH  instruction word to write.
- core_rst  out  1  reset held on the CPU core while loading.
- load_done  out  1  program loaded; core released.
- load_error  out  1  load aborted.

Function
REQ-003 Byte stream format: 4-byte word count N (little-endian, unsigned 32-bit), followed by N instructions of 4 bytes each (little-endian).
REQ-004 FSM states: HDR (collect count), DATA (collect instructions), DONE, ERROR.
REQ-005 rx_ready SHALL be 1 in HDR and DATA, and 0 in DONE and ERROR.
REQ-006 On the edge accepting the 4th header byte:
- N=0 -> DONE.
- N>MAX_WORDS -> ERROR.
- otherwise -> DATA, with word index cleared to 0.
REQ-007 In DATA, bytes SHALL assemble into bits [7:0], [15:8], [23:16], [31:24] in arrival order.
REQ-008 On the edge accepting a word's 4th byte, the following SHALL be registered:
- dbg_wr_en=1.
- dbg_instr=assembled word.
- dbg_addr=BASE_ADDR+4*index, computed modulo 2^XLEN.
- index incremented.
REQ-009 dbg_wr_en SHALL be high for exactly one cycle per word; dbg_addr and dbg_instr SHALL hold their values until the next write.
REQ-010 Write latency SHALL be 1 cycle from the 4th-byte handshake edge to dbg_wr_en high. Back-to-back words at 1 byte per cycle SHALL produce a write every 4 cycles, with no lost bytes.
REQ-011 On the edge accepting the final byte of word N-1, the FSM SHALL enter DONE; that write pulse SHALL still occur.
REQ-012 core_rst SHALL be 1 in HDR, DATA and ERROR. core_rst SHALL fall 1 cycle after the last dbg_wr_en pulse, or 1 cycle after entering DONE when N=0. load_done SHALL rise in the same cycle that core_rst falls.
REQ-013 Timeout counter behaviour:
- Cleared on every accepted byte.
- Incremented each cycle in DATA, and in HDR once at least one header byte has been accepted.
- On reaching TIMEOUT_CYCLES the FSM SHALL enter ERROR and any partial word SHALL be discarded.
REQ-014 In ERROR, load_error SHALL be 1 and no writes SHALL be issued.
REQ-015 reload=1 in DONE or ERROR SHALL, at the next edge, enter HDR and:
- set core_rst=1;
- clear load_done, load_error, byte counter, index and timeout counter.
REQ-016 reload SHALL be ignored in HDR and DATA.
REQ-017 rx_data SHALL be ignored when rx_valid=0. A byte with rx_valid=1 in DONE or ERROR SHALL NOT be consumed.
REQ-018 If rst and reload are asserted together, rst SHALL take priority.

Reset
REQ-019 rst SHALL, at the next edge, set:
- state=HDR;
- rx_ready=1, dbg_wr_en=0, dbg_addr=0, dbg_instr=0;
- core_rst=1, load_done=0, load_error=0;
- all counters and the partial word cleared.
REQ-020 rst mid-load SHALL discard all progress. The next accepted byte SHALL be treated as header byte 0, and instruction memory already written SHALL NOT be rewritten.

Verification
REQ-021 Normal load, streamed 1 byte/cycle:
- Bytes 02 00 00 00 | 13 05 10 00 | 93 05 20 00.
- Required: writes (addr 0x0, data 0x00100513) and (addr 0x4, data 0x00200593), 4 cycles apart.
- Required: core_rst falls 1 cycle after the second write; load_done=1.
REQ-022 Throttled stream (rx_valid toggling every other cycle, same bytes as REQ-021) -> identical writes and data. No extra dbg_wr_en pulses.
REQ-023 Count checks:
- Header 00 00 00 00 -> no writes, DONE, core_rst falls 1 cycle later.
- Header 01 04 00 00 (N=1025) -> ERROR, load_error=1, rx_ready=0, core_rst stays 1.
REQ-024 Timeout: TIMEOUT_CYCLES=16, header N=1, then 2 data bytes, then idle -> ERROR 16 cycles after the last accepted byte, with no write. Then reload=1 -> HDR with core_rst=1 and flags clear, and a following valid load succeeds.
REQ-025 rst asserted after 6 bytes of a 2-word load:
- Required: all outputs return to reset values.
- A fresh stream with N=1 writes only address 0x0 with the new word.
REQ-026 BASE_ADDR=0xFFFFFFFFFFFFFFFC, N=2 -> writes at 0xFFFFFFFFFFFFFFFC, then 0x0 (wrap-around).

Source files
------------

// File: rtl/program_loader.sv
// Serial program loader: takes a little-endian word count and instruction stream from a
// byte link, writes each instruction through the core debug port, and holds the core in reset.
module program_loader #(
  parameter int unsigned     XLEN               = 64,
  parameter int unsigned     INSTRUCTION_LENGTH = 32,
  parameter logic [XLEN-1:0] BASE_ADDR          = '0,
  parameter int unsigned     MAX_WORDS          = 1024,
  parameter int unsigned     TIMEOUT_CYCLES     = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready,
  input  logic                          reload,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          load_done,
  output logic                          load_error
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      MAX_N    = 32'(MAX_WORDS);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    DATA  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t                        state, state_nxt;
  logic [1:0]                    byte_cnt, byte_cnt_nxt;
  logic [23:0]                   partial, partial_nxt;
  logic [31:0]                   word_count, word_count_nxt;
  logic [31:0]                   index, index_nxt;
  logic [XLEN-1:0]               wr_addr, wr_addr_nxt;
  logic [TMO_W-1:0]              tmo, tmo_nxt;
  logic                          wr_en_nxt;
  logic [XLEN-1:0]               addr_nxt;
  logic [INSTRUCTION_LENGTH-1:0] instr_nxt;
  logic                          rx_ready_nxt;
  logic                          core_rst_nxt;
  logic                          load_done_nxt;
  logic                          load_error_nxt;
  logic                          accept_c;
  logic [31:0]                   word_c;

  // Registers: FSM state, assembly datapath and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR;
      byte_cnt   <= '0;
      partial    <= '0;
      word_count <= '0;
      index      <= '0;
      wr_addr    <= '0;
      tmo        <= '0;
      rx_ready   <= 1'b1;
      dbg_wr_en  <= 1'b0;
      dbg_addr   <= '0;
      dbg_instr  <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      partial    <= partial_nxt;
      word_count <= word_count_nxt;
      index      <= index_nxt;
      wr_addr    <= wr_addr_nxt;
      tmo        <= tmo_nxt;
      rx_ready   <= rx_ready_nxt;
      dbg_wr_en  <= wr_en_nxt;
      dbg_addr   <= addr_nxt;
      dbg_instr  <= instr_nxt;
      core_rst   <= core_rst_nxt;
      load_done  <= load_done_nxt;
      load_error <= load_error_nxt;
    end
  end

  // Next-state, byte assembly, debug-port write and idle timeout.
  always_comb begin
    state_nxt      = state;
    byte_cnt_nxt   = byte_cnt;
    partial_nxt    = partial;
    word_count_nxt = word_count;
    index_nxt      = index;
    wr_addr_nxt    = wr_addr;
    tmo_nxt        = tmo;
    wr_en_nxt      = 1'b0;
    addr_nxt       = dbg_addr;
    instr_nxt      = dbg_instr;
    accept_c       = rx_valid && rx_ready;
    word_c         = {rx_data, partial};

    unique case (state)
      HDR, DATA: begin
        if (accept_c) begin
          tmo_nxt      = '0;
          byte_cnt_nxt = byte_cnt + 2'd1;
          unique case (byte_cnt)
            2'd0:    partial_nxt[7:0]   = rx_data;
            2'd1:    partial_nxt[15:8]  = rx_data;
            2'd2:    partial_nxt[23:16] = rx_data;
            default: partial_nxt        = '0;
          endcase
          if (byte_cnt == 2'd3) begin
            if (state == HDR) begin
              word_count_nxt = word_c;
              index_nxt      = '0;
              wr_addr_nxt    = BASE_ADDR;
              if (word_c == 32'd0) begin
                state_nxt = DONE;
              end else if (word_c > MAX_N) begin
                state_nxt = ERROR;
              end else begin
                state_nxt = DATA;
              end
            end else begin
              wr_en_nxt   = 1'b1;
              addr_nxt    = wr_addr;
              instr_nxt   = INSTRUCTION_LENGTH'(word_c);
              wr_addr_nxt = wr_addr + XLEN'(4);
              index_nxt   = index + 32'd1;
              if (index == word_count - 32'd1) begin
                state_nxt = DONE;
              end
            end
          end
        end else if (state == DATA || byte_cnt != 2'd0) begin
          // Idle gap only counts once a load is in progress; a partial word is dropped on expiry.
          if (tmo == TMO_LAST) begin
            state_nxt    = ERROR;
            byte_cnt_nxt = '0;
            partial_nxt  = '0;
            tmo_nxt      = '0;
          end else begin
            tmo_nxt = tmo + TMO_W'(1);
          end
        end
      end
      default: begin
        if (reload) begin
          state_nxt    = HDR;
          byte_cnt_nxt = '0;
          partial_nxt  = '0;
          index_nxt    = '0;
          tmo_nxt      = '0;
        end
      end
    endcase

    // Core release lags DONE entry by one cycle so the final write lands first.
    rx_ready_nxt   = (state_nxt == HDR) || (state_nxt == DATA);
    load_done_nxt  = (state == DONE) && (state_nxt == DONE);
    core_rst_nxt   = !load_done_nxt;
    load_error_nxt = (state_nxt == ERROR);
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected debug writes, a negedge monitor checks them.
module tb_program_loader;

  localparam logic [63:0] WBASE = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        rx_ready,   w_rx_ready;
  logic        dbg_wr_en,  w_dbg_wr_en;
  logic [63:0] dbg_addr,   w_dbg_addr;
  logic [31:0] dbg_instr,  w_dbg_instr;
  logic        core_rst,   w_core_rst;
  logic        load_done,  w_load_done;
  logic        load_error, w_load_error;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  wr_t         exp_q[$];
  wr_t         exp_w_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  stim[$];

  program_loader #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .core_rst(core_rst), .load_done(load_done), .load_error(load_error)
  );

  program_loader #(.BASE_ADDR(WBASE), .TIMEOUT_CYCLES(16)) u_wrap (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(w_rx_ready),
    .reload(reload), .dbg_wr_en(w_dbg_wr_en), .dbg_addr(w_dbg_addr), .dbg_instr(w_dbg_instr),
    .core_rst(w_core_rst), .load_done(w_load_done), .load_error(w_load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    cyc++;
    if (dbg_wr_en) begin
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", dbg_addr, dbg_instr);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", dbg_addr, e.addr);
        check_val("wr_data", 64'(dbg_instr), 64'(e.data));
      end
    end
    if (w_dbg_wr_en) begin
      if (exp_w_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wrap_write: got addr %h data %h expected none", w_dbg_addr, w_dbg_instr);
      end else begin
        e = exp_w_q.pop_front();
        check_val("wrap_wr_addr", w_dbg_addr, e.addr);
        check_val("wrap_wr_data", 64'(w_dbg_instr), 64'(e.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_word(input logic [31:0] w);
    stim.push_back(w[7:0]);
    stim.push_back(w[15:8]);
    stim.push_back(w[23:16]);
    stim.push_back(w[31:24]);
  endtask

  // Reference: parse the complete stream and list the writes it should produce.
  task automatic model_push();
    logic [31:0] n;
    logic [31:0] w;
    n = {stim[3], stim[2], stim[1], stim[0]};
    if (n == 32'd0 || n > 32'd1024) return;
    for (int i = 0; i < int'(n); i++) begin
      w = {stim[4*i+7], stim[4*i+6], stim[4*i+5], stim[4*i+4]};
      exp_q.push_back('{addr: 64'(4 * i), data: w});
      exp_w_q.push_back('{addr: WBASE + 64'(4 * i), data: w});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   guard;
    logic hs;
    guard    = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      hs = rx_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!hs && guard < 50);
    if (!hs) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout: got rx_ready 0 expected 1");
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int min_gap, input int max_gap, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(max_gap, min_gap)) begin
        rx_data = 8'($urandom);
        step(1);
      end
      send_byte(stim[i]);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step(1);
    reload = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_bit({tag, "_rx_ready"}, rx_ready, 1'b1);
    check_bit({tag, "_wr_en"}, dbg_wr_en, 1'b0);
    check_val({tag, "_addr"}, dbg_addr, 64'd0);
    check_val({tag, "_wrap_addr"}, w_dbg_addr, 64'd0);
    check_val({tag, "_instr"}, 64'(dbg_instr), 64'd0);
    check_bit({tag, "_core_rst"}, core_rst, 1'b1);
    check_bit({tag, "_load_done"}, load_done, 1'b0);
    check_bit({tag, "_load_error"}, load_error, 1'b0);
  endtask

  task automatic check_after_reload(input string tag);
    check_bit({tag, "_core_rst"}, core_rst, 1'b1);
    check_bit({tag, "_load_done"}, load_done, 1'b0);
    check_bit({tag, "_load_error"}, load_error, 1'b0);
    check_bit({tag, "_rx_ready"}, rx_ready, 1'b1);
  endtask

  task automatic normal_stream();
    stim.delete();
    add_word(32'd2);
    add_word(32'h0010_0513);
    add_word(32'h0020_0593);
  endtask

  initial begin
    rst      = 1'b1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    step(3);
    rst = 1'b0;
    check_reset("reset");

    // Two-word load streamed back to back; second instance covers address wrap.
    normal_stream();
    model_push();
    wr_cyc_q.delete();
    send_stream(0, 0, stim.size());
    check_bit("stream_ready_in_done", rx_ready, 1'b0);
    check_bit("stream_core_rst_hold", core_rst, 1'b1);
    check_bit("stream_done_early", load_done, 1'b0);
    step(1);
    check_bit("stream_core_rst_fall", core_rst, 1'b0);
    check_bit("stream_load_done", load_done, 1'b1);
    check_bit("stream_wrap_done", w_load_done, 1'b1);
    check_val("stream_write_count", 64'(wr_cyc_q.size()), 64'd2);
    if (wr_cyc_q.size() == 2)
      check_val("stream_write_gap", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd4);

    // Same load with rx_valid toggling every other cycle.
    do_reload();
    check_after_reload("reload1");
    normal_stream();
    model_push();
    wr_cyc_q.delete();
    send_stream(1, 1, stim.size());
    step(1);
    check_bit("throttle_load_done", load_done, 1'b1);
    check_val("throttle_write_count", 64'(wr_cyc_q.size()), 64'd2);

    // Zero-length program.
    do_reload();
    stim.delete();
    add_word(32'd0);
    send_stream(0, 0, 4);
    check_bit("n0_ready", rx_ready, 1'b0);
    check_bit("n0_core_rst_hold", core_rst, 1'b1);
    step(1);
    check_bit("n0_core_rst_fall", core_rst, 1'b0);
    check_bit("n0_load_done", load_done, 1'b1);

    // Oversized count, then bytes offered in ERROR must not be consumed.
    do_reload();
    stim.delete();
    add_word(32'd1025);
    send_stream(0, 0, 4);
    check_bit("big_load_error", load_error, 1'b1);
    check_bit("big_ready", rx_ready, 1'b0);
    check_bit("big_core_rst", core_rst, 1'b1);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    step(3);
    rx_valid = 1'b0;
    check_bit("big_ready_hold", rx_ready, 1'b0);
    check_bit("big_core_rst_hold", core_rst, 1'b1);
    check_bit("big_done_clear", load_done, 1'b0);

    // Idle timeout after a partial word, then recovery.
    do_reload();
    stim.delete();
    add_word(32'd1);
    add_word($urandom);
    send_stream(0, 0, 6);
    step(15);
    check_bit("tmo_not_yet", load_error, 1'b0);
    step(1);
    check_bit("tmo_load_error", load_error, 1'b1);
    check_bit("tmo_ready", rx_ready, 1'b0);
    check_bit("tmo_core_rst", core_rst, 1'b1);
    do_reload();
    check_after_reload("reload_tmo");
    stim.delete();
    add_word(32'd1);
    add_word($urandom);
    model_push();
    send_stream(0, 2, stim.size());
    step(1);
    check_bit("tmo_recover_done", load_done, 1'b1);

    // Reset in the middle of a two-word load.
    do_reload();
    stim.delete();
    add_word(32'd2);
    add_word($urandom);
    add_word($urandom);
    send_stream(0, 0, 6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset("midrst");
    stim.delete();
    add_word(32'd1);
    add_word($urandom);
    model_push();
    send_stream(0, 0, stim.size());
    step(1);
    check_bit("midrst_done", load_done, 1'b1);

    // Random programs with random inter-byte gaps.
    for (int k = 0; k < 8; k++) begin
      do_reload();
      stim.delete();
      add_word(32'($urandom_range(6, 1)));
      for (int j = 0; j < int'(stim[0]); j++) add_word($urandom);
      model_push();
      send_stream(0, 3, stim.size());
      step(1);
      check_bit("rand_load_done", load_done, 1'b1);
      check_bit("rand_core_rst", core_rst, 1'b0);
    end

    step(3);
    check_val("pending_writes", 64'(exp_q.size()), 64'd0);
    check_val("pending_wrap_writes", 64'(exp_w_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
